// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, LSB-first data, optional parity and stop
// bits, and tells the line mux which source to drive each bit-clock cycle.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  SER_DATA,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_reg;
    logic                  load;
    logic                  last_bit;

    // A new frame may only be accepted while idle or on the final stop cycle.
    assign load     = DATA_VALID && ((state == IDLE) || (state == STOP));
    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mux_sel    = 2'b01;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (DATA_VALID) next_state = START;
            end
            START: begin
                mux_sel    = 2'b00;
                busy       = 1'b1;
                next_state = DATA;
            end
            DATA: begin
                mux_sel = 2'b10;
                busy    = 1'b1;
                if (last_bit) next_state = par_en_reg ? PARITY : STOP;
            end
            PARITY: begin
                mux_sel    = 2'b11;
                busy       = 1'b1;
                next_state = STOP;
            end
            STOP: begin
                busy       = 1'b1;
                next_state = DATA_VALID ? START : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // SER_DATA is registered one bit ahead of the DATA cycle it serves, so it
    // naturally holds the final data bit once the frame moves past DATA.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_reg   <= '0;
            bit_cnt    <= '0;
            SER_DATA   <= 1'b0;
            par_bit    <= 1'b0;
            par_en_reg <= 1'b0;
        end else if (load) begin
            data_reg   <= P_DATA;
            par_en_reg <= PAR_EN;
            par_bit    <= (^P_DATA) ^ PAR_TYP;
            bit_cnt    <= '0;
        end else if (state == START) begin
            SER_DATA <= data_reg[0];
            data_reg <= data_reg >> 1;
        end else if (state == DATA) begin
            if (last_bit) begin
                bit_cnt <= '0;
            end else begin
                SER_DATA <= data_reg[0];
                data_reg <= data_reg >> 1;
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of whole frames on an 8-bit instance plus
// hand sequences for back-to-back frames, mid-frame reset and a 5-bit instance.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [1:0] mux_sel;
    logic       ser_data;
    logic       par_bit;
    logic       busy;

    logic [4:0] p_data5;
    logic       data_valid5;
    logic       par_en5;
    logic       par_typ5;
    logic [1:0] mux_sel5;
    logic       ser_data5;
    logic       par_bit5;
    logic       busy5;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [7:0] mid;
        logic [7:0] exp_bits;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[7];

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut8 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .mux_sel    (mux_sel),
        .SER_DATA   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data5),
        .DATA_VALID (data_valid5),
        .PAR_EN     (par_en5),
        .PAR_TYP    (par_typ5),
        .mux_sel    (mux_sel5),
        .SER_DATA   (ser_data5),
        .par_bit    (par_bit5),
        .busy       (busy5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame from the table on the 8-bit instance, scribbling on the
    // inputs mid-frame, and checks every cycle from START through return to IDLE.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int busy_cnt;
        busy_cnt   = 0;
        data_valid = 1'b1;
        p_data     = v.data;
        par_en     = v.pe;
        par_typ    = v.pt;
        @(negedge CLK);
        check_output($sformatf("v%0d start mux", idx), 32'(mux_sel), 32'h0);
        check_output($sformatf("v%0d start busy", idx), 32'(busy), 32'h1);
        busy_cnt   += int'(busy);
        data_valid = 1'b0;
        p_data     = v.mid;
        par_en     = ~v.pe;
        par_typ    = ~v.pt;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check_output($sformatf("v%0d data%0d mux", idx, k), 32'(mux_sel), 32'h2);
            check_output($sformatf("v%0d data%0d ser", idx, k), 32'(ser_data), 32'(v.exp_bits[k]));
            check_output($sformatf("v%0d data%0d par", idx, k), 32'(par_bit), 32'(v.exp_par));
            busy_cnt += int'(busy);
            data_valid = (k == 2);
        end
        data_valid = 1'b0;
        if (v.pe) begin
            @(negedge CLK);
            check_output($sformatf("v%0d parity mux", idx), 32'(mux_sel), 32'h3);
            check_output($sformatf("v%0d parity par", idx), 32'(par_bit), 32'(v.exp_par));
            busy_cnt += int'(busy);
        end
        @(negedge CLK);
        check_output($sformatf("v%0d stop mux", idx), 32'(mux_sel), 32'h1);
        check_output($sformatf("v%0d stop busy", idx), 32'(busy), 32'h1);
        busy_cnt += int'(busy);
        @(negedge CLK);
        check_output($sformatf("v%0d idle mux", idx), 32'(mux_sel), 32'h1);
        check_output($sformatf("v%0d idle busy", idx), 32'(busy), 32'h0);
        check_output($sformatf("v%0d busy len", idx), 32'(busy_cnt), 32'(v.exp_len));
    endtask

    initial begin
        logic [7:0] bits55;
        logic [7:0] bits0f;
        logic [4:0] bits5;
        int         busy_cnt;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 8'hFF, 8'hA5, 1'b1, 11};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 8'hFF, 8'h07, 1'b1, 11};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 11};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 10};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 8'h7F, 8'h80, 1'b1, 11};

        RST         = 1'b0;
        p_data      = 8'h00;
        data_valid  = 1'b0;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        p_data5     = 5'h00;
        data_valid5 = 1'b0;
        par_en5     = 1'b0;
        par_typ5    = 1'b0;

        #1;
        check_output("reset mux", 32'(mux_sel), 32'h1);
        check_output("reset busy", 32'(busy), 32'h0);
        check_output("reset ser", 32'(ser_data), 32'h0);
        check_output("reset par", 32'(par_bit), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_output("post-reset idle mux", 32'(mux_sel), 32'h1);
        check_output("post-reset idle busy", 32'(busy), 32'h0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Back-to-back frames with DATA_VALID held: 0x55 then 0x0F, no parity.
        bits55     = 8'h55;
        bits0f     = 8'h0F;
        data_valid = 1'b1;
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        @(negedge CLK);
        check_output("b2b start1 mux", 32'(mux_sel), 32'h0);
        p_data = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check_output($sformatf("b2b f1 data%0d", k), 32'(ser_data), 32'(bits55[k]));
        end
        @(negedge CLK);
        check_output("b2b stop1 mux", 32'(mux_sel), 32'h1);
        check_output("b2b stop1 busy", 32'(busy), 32'h1);
        @(negedge CLK);
        check_output("b2b start2 mux", 32'(mux_sel), 32'h0);
        check_output("b2b start2 busy", 32'(busy), 32'h1);
        data_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check_output($sformatf("b2b f2 mux%0d", k), 32'(mux_sel), 32'h2);
            check_output($sformatf("b2b f2 data%0d", k), 32'(ser_data), 32'(bits0f[k]));
        end
        @(negedge CLK);
        check_output("b2b stop2 busy", 32'(busy), 32'h1);
        @(negedge CLK);
        check_output("b2b idle busy", 32'(busy), 32'h0);

        // Reset asserted in the 4th DATA cycle must clear outputs without a clock edge.
        data_valid = 1'b1;
        p_data     = 8'hA5;
        @(negedge CLK);
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
        end
        check_output("pre-abort mux", 32'(mux_sel), 32'h2);
        #2;
        RST = 1'b0;
        #1;
        check_output("abort mux", 32'(mux_sel), 32'h1);
        check_output("abort busy", 32'(busy), 32'h0);
        check_output("abort ser", 32'(ser_data), 32'h0);
        check_output("abort par", 32'(par_bit), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check_output($sformatf("post-abort idle%0d", k), 32'({busy, mux_sel}), 32'h1);
        end

        // 5-bit instance: 10011 with odd parity.
        bits5       = 5'b10011;
        busy_cnt    = 0;
        data_valid5 = 1'b1;
        p_data5     = 5'b10011;
        par_en5     = 1'b1;
        par_typ5    = 1'b1;
        @(negedge CLK);
        check_output("w5 start mux", 32'(mux_sel5), 32'h0);
        busy_cnt   += int'(busy5);
        data_valid5 = 1'b0;
        p_data5     = 5'b01100;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check_output($sformatf("w5 data%0d mux", k), 32'(mux_sel5), 32'h2);
            check_output($sformatf("w5 data%0d ser", k), 32'(ser_data5), 32'(bits5[k]));
            busy_cnt += int'(busy5);
        end
        @(negedge CLK);
        check_output("w5 parity mux", 32'(mux_sel5), 32'h3);
        check_output("w5 parity par", 32'(par_bit5), 32'h0);
        busy_cnt += int'(busy5);
        @(negedge CLK);
        check_output("w5 stop mux", 32'(mux_sel5), 32'h1);
        busy_cnt += int'(busy5);
        @(negedge CLK);
        check_output("w5 idle busy", 32'(busy5), 32'h0);
        check_output("w5 busy len", 32'(busy_cnt), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
